// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and default widths for the VGA memory arbiter, pattern and SPI blocks.
package vga_mem_pkg;

  localparam int VGA_ADDR_W = 10;
  localparam int VGA_DATA_W = 8;

  // Which requester owns the single RAM port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DISP = 2'd1,
    SRC_HRD  = 2'd2,
    SRC_HWR  = 2'd3
  } slot_src_e;

endpackage

// File: rtl/vga_mem_arbiter_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through head, used to buffer host writes.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             do_push, do_pop;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  // The head is read combinationally so the arbiter can issue it in the same cycle.
  assign rdata   = mem[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: display fetches always win, host reads next, buffered host
// writes drain into otherwise idle cycles.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = VGA_ADDR_W,
  parameter int DATA_W     = VGA_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          disp_req,
  input  logic [ADDR_W-1:0]             disp_addr,
  output logic                          disp_rvalid,
  output logic [DATA_W-1:0]             disp_rdata,
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_W-1:0]             host_wr_addr,
  input  logic [DATA_W-1:0]             host_wr_data,
  input  logic                          host_rd_valid,
  output logic                          host_rd_ready,
  input  logic [ADDR_W-1:0]             host_rd_addr,
  output logic                          host_rd_rvalid,
  output logic [DATA_W-1:0]             host_rd_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [STALL_W-1:0]            stall_cnt
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  slot_src_e           slot;
  slot_src_e           last_src_reg;
  logic                rd_pending_reg, rd_pending_next;
  logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
  logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                rd_accept, rd_want;
  logic [ADDR_W-1:0]   rd_addr_eff;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({host_wr_addr, host_wr_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A read is only accepted with no older write queued or arriving, so it can never
  // overtake a write the host has already handed over.
  assign host_wr_ready = !fifo_full;
  assign fifo_push     = host_wr_valid && !fifo_full;
  assign host_rd_ready = fifo_empty && !rd_pending_reg && !fifo_push;
  assign rd_accept     = host_rd_valid && host_rd_ready;
  assign rd_want       = rd_pending_reg || rd_accept;
  assign rd_addr_eff   = rd_pending_reg ? rd_addr_reg : host_rd_addr;
  assign fifo_pop      = (slot == SRC_HWR);

  always_comb begin
    slot = SRC_NONE;
    if (!rst) begin
      if (disp_req)         slot = SRC_DISP;
      else if (rd_want)     slot = SRC_HRD;
      else if (!fifo_empty) slot = SRC_HWR;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (slot)
      SRC_DISP: begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end
      SRC_HRD: begin
        mem_en   = 1'b1;
        mem_addr = rd_addr_eff;
      end
      SRC_HWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fifo_head[ENTRY_W-1:DATA_W];
        mem_wdata = fifo_head[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_pending_next = rd_pending_reg;
    rd_addr_next    = rd_addr_reg;
    stall_cnt_next  = stall_cnt_reg;
    if (rd_accept) rd_addr_next = host_rd_addr;
    if (slot == SRC_HRD)  rd_pending_next = 1'b0;
    else if (rd_accept)   rd_pending_next = 1'b1;
    if ((slot == SRC_DISP) && (rd_pending_reg || !fifo_empty) &&
        (stall_cnt_reg != {STALL_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_src_reg   <= SRC_NONE;
      rd_pending_reg <= 1'b0;
      rd_addr_reg    <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      last_src_reg   <= slot;
      rd_pending_reg <= rd_pending_next;
      rd_addr_reg    <= rd_addr_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign disp_rvalid    = (last_src_reg == SRC_DISP);
  assign host_rd_rvalid = (last_src_reg == SRC_HRD);
  assign disp_rdata     = mem_rdata;
  assign host_rd_rdata  = mem_rdata;
  assign stall_cnt      = stall_cnt_reg;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a behavioural single-port RAM attached.
module tb_vga_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_req;
  logic [9:0] disp_addr;
  logic       disp_rvalid;
  logic [7:0] disp_rdata;
  logic       host_wr_valid;
  logic       host_wr_ready;
  logic [9:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_rd_valid;
  logic       host_rd_ready;
  logic [9:0] host_rd_addr;
  logic       host_rd_rvalid;
  logic [7:0] host_rd_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [2:0] fifo_level;
  logic [3:0] stall_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .ADDR_W     (10),
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .STALL_W    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .host_wr_valid  (host_wr_valid),
    .host_wr_ready  (host_wr_ready),
    .host_wr_addr   (host_wr_addr),
    .host_wr_data   (host_wr_data),
    .host_rd_valid  (host_rd_valid),
    .host_rd_ready  (host_rd_ready),
    .host_rd_addr   (host_rd_addr),
    .host_rd_rvalid (host_rd_rvalid),
    .host_rd_rdata  (host_rd_rdata),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .fifo_level     (fifo_level),
    .stall_cnt      (stall_cnt)
  );

  // RAM model: preset to addr>>2 while rst is high, then plain read/write port.
  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'(i >> 2);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_valid = 1'b0; host_rd_addr = '0;
  endtask

  initial begin
    int w;
    int exp_ready;
    int exp_stall;
    mem_rdata = '0;
    rst = 1'b1;
    idle_inputs();

    // Reset held 3 cycles with random inputs
    for (int k = 0; k < 3; k++) begin
      disp_req      = 1'($urandom);
      disp_addr     = 10'($urandom);
      host_wr_valid = 1'($urandom);
      host_wr_addr  = 10'($urandom);
      host_wr_data  = 8'($urandom);
      host_rd_valid = 1'($urandom);
      host_rd_addr  = 10'($urandom);
      #1;
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rel_wr_ready", 32'(host_wr_ready), 1);
    chk("rel_rd_ready", 32'(host_rd_ready), 1);
    chk("rel_level", 32'(fifo_level), 0);
    chk("rel_stall", 32'(stall_cnt), 0);
    chk("rel_disp_rvalid", 32'(disp_rvalid), 0);
    chk("rel_rd_rvalid", 32'(host_rd_rvalid), 0);
    step();

    // FIFO fills under a 10-cycle display hold
    host_wr_valid = 1'b1; host_wr_addr = 10'h010; host_wr_data = 8'hA0;
    #1;
    chk("fill_first_ready", 32'(host_wr_ready), 1);
    chk("fill_first_idle", 32'(mem_en), 0);
    step();
    w = 1;
    for (int c = 0; c < 10; c++) begin
      disp_req = 1'b1; disp_addr = 10'(c);
      host_wr_valid = (w < 5);
      host_wr_addr = 10'(16 + w); host_wr_data = 8'(160 + w);
      #1;
      exp_ready = (c < 3) ? 1 : 0;
      chk("hold_mem_addr", 32'(mem_addr), 32'(c));
      chk("hold_mem_we", 32'(mem_we), 0);
      chk("hold_wr_ready", 32'(host_wr_ready), 32'(exp_ready));
      if (host_wr_valid && exp_ready == 1) w++;
      step();
    end
    chk("hold_level", 32'(fifo_level), 4);
    chk("hold_stall", 32'(stall_cnt), 10);
    chk("hold_disp_rvalid", 32'(disp_rvalid), 1);

    // Drain: five back-to-back writes in arrival order
    disp_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      host_wr_valid = (w < 5);
      #1;
      exp_ready = (c != 0) ? 1 : 0;
      chk("drain_we", 32'(mem_we), 1);
      chk("drain_addr", 32'(mem_addr), 32'(16 + c));
      chk("drain_wdata", 32'(mem_wdata), 32'(160 + c));
      chk("drain_wr_ready", 32'(host_wr_ready), 32'(exp_ready));
      if (host_wr_valid && exp_ready == 1) w++;
      step();
    end
    host_wr_valid = 1'b0;
    #1;
    chk("drain_idle", 32'(mem_en), 0);
    chk("drain_level", 32'(fifo_level), 0);
    step();

    // Read-after-write to 0x055
    host_wr_valid = 1'b1; host_wr_addr = 10'h055; host_wr_data = 8'h3C;
    #1;
    chk("raw_ready_push", 32'(host_rd_ready), 0);
    step();
    host_wr_valid = 1'b0;
    host_rd_valid = 1'b1; host_rd_addr = 10'h055;
    #1;
    chk("raw_ready_queued", 32'(host_rd_ready), 0);
    chk("raw_wr_we", 32'(mem_we), 1);
    chk("raw_wr_addr", 32'(mem_addr), 32'h055);
    step();
    #1;
    chk("raw_ready_empty", 32'(host_rd_ready), 1);
    chk("raw_rd_en", 32'(mem_en), 1);
    chk("raw_rd_we", 32'(mem_we), 0);
    chk("raw_rd_addr", 32'(mem_addr), 32'h055);
    step();
    host_rd_valid = 1'b0;
    #1;
    chk("raw_rvalid", 32'(host_rd_rvalid), 1);
    chk("raw_rdata", 32'(host_rd_rdata), 32'h3C);
    step();
    #1;
    chk("raw_rvalid_clear", 32'(host_rd_rvalid), 0);

    // Display and host read collide in the same cycle
    disp_req = 1'b1; disp_addr = 10'h100;
    host_rd_valid = 1'b1; host_rd_addr = 10'h200;
    #1;
    chk("col_rd_ready", 32'(host_rd_ready), 1);
    chk("col_addr_t", 32'(mem_addr), 32'h100);
    step();
    disp_req = 1'b0; host_rd_valid = 1'b0;
    #1;
    chk("col_addr_t1", 32'(mem_addr), 32'h200);
    chk("col_disp_rvalid", 32'(disp_rvalid), 1);
    chk("col_disp_rdata", 32'(disp_rdata), 32'h40);
    chk("col_rd_rvalid_t1", 32'(host_rd_rvalid), 0);
    chk("col_rd_busy", 32'(host_rd_ready), 0);
    chk("col_stall", 32'(stall_cnt), 10);
    step();
    #1;
    chk("col_rd_rvalid_t2", 32'(host_rd_rvalid), 1);
    chk("col_rd_rdata", 32'(host_rd_rdata), 32'h80);
    chk("col_disp_rvalid_t2", 32'(disp_rvalid), 0);

    // Reset with a pending read and three queued writes
    disp_req = 1'b1; disp_addr = 10'h000;
    host_rd_valid = 1'b1; host_rd_addr = 10'h3FF;
    #1;
    chk("mid_rd_accept", 32'(host_rd_ready), 1);
    step();
    host_rd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      host_wr_valid = 1'b1; host_wr_addr = 10'(768 + c); host_wr_data = 8'(17 + c);
      #1;
      chk("mid_wr_ready", 32'(host_wr_ready), 1);
      step();
    end
    host_wr_valid = 1'b0;
    #1;
    chk("mid_level", 32'(fifo_level), 3);
    chk("mid_stall", 32'(stall_cnt), 13);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(mem_en), 0);
    chk("mid_rst_we", 32'(mem_we), 0);
    step();
    rst = 1'b0; disp_req = 1'b0;
    #1;
    chk("mid_post_level", 32'(fifo_level), 0);
    chk("mid_post_stall", 32'(stall_cnt), 0);
    chk("mid_post_rd_ready", 32'(host_rd_ready), 1);
    for (int c = 0; c < 6; c++) begin
      chk("mid_post_en", 32'(mem_en), 0);
      chk("mid_post_we", 32'(mem_we), 0);
      chk("mid_post_rvalid", 32'(host_rd_rvalid), 0);
      step();
    end

    // Stall counter saturates at 15 under a 40-cycle display hold
    disp_req = 1'b1; disp_addr = 10'h001;
    host_wr_valid = 1'b1; host_wr_addr = 10'h0AA; host_wr_data = 8'h77;
    #1;
    step();
    host_wr_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      exp_stall = (k - 1 > 15) ? 15 : k - 1;
      if (k % 4 == 1) chk("sat_progress", 32'(stall_cnt), 32'(exp_stall));
      step();
    end
    disp_req = 1'b0;
    #1;
    chk("sat_final", 32'(stall_cnt), 15);
    chk("sat_drain_we", 32'(mem_we), 1);
    chk("sat_drain_addr", 32'(mem_addr), 32'h0AA);
    chk("sat_drain_wdata", 32'(mem_wdata), 32'h77);
    step();
    #1;
    chk("sat_level", 32'(fifo_level), 0);
    chk("sat_hold", 32'(stall_cnt), 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
- Single-port pixel/tile RAM arbiter between the VGA display fetch path and the SPI host command path.
- Display reads always win and have fixed 1-cycle latency, so scanout never glitches.
- Host writes are buffered in a small FIFO and drained into free slots (idle and blanking cycles).
- Host reads are single-outstanding and coherent with earlier accepted host writes.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width (2b R/G/B + 2b attr).
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, >=2).
- STALL_W, 8, width of saturating host-stall counter.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- rst  in  1  synchronous reset, active-high.
- disp_req  in  1  display fetch request this cycle.
- disp_addr  in  ADDR_W  display fetch address.
- disp_rvalid  out  1  display data valid (1 cycle after disp_req).
- disp_rdata  out  DATA_W  display read data (= mem_rdata).
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  FIFO can accept a write.
- host_wr_addr  in  ADDR_W  host write address.
- host_wr_data  in  DATA_W  host write data.
- host_rd_valid  in  1  host read request.
- host_rd_ready  out  1  host read accepted this cycle when valid.
- host_rd_addr  in  ADDR_W  host read address.
- host_rd_rvalid  out  1  host read data valid.
- host_rd_rdata  out  DATA_W  host read data (= mem_rdata).
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after an enabled read.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- stall_cnt  out  STALL_W  count of cycles with host work pending but slot lost to display; saturates.

Behaviour:
- One RAM access per cycle. Slot priority, evaluated combinationally each cycle:
  1. DISP: disp_req=1.
  2. HRD: a host read is pending.
  3. HWR: FIFO is non-empty (head entry).
  4. NONE: mem_en=0.
- mem_en/mem_we/mem_addr/mem_wdata are combinational from the slot decision.
  - mem_we=1 only in HWR.
  - mem_wdata=0 when not HWR.
  - While rst=1, all mem_* outputs are 0.
- last_src register (NONE/DISP/HRD/HWR) records the slot issued in the previous cycle.
  - disp_rvalid = (last_src==DISP); host_rd_rvalid = (last_src==HRD).
  - Both rdata outputs carry mem_rdata unregistered.
- Write FIFO:
  - host_wr_ready = !full. Push on valid&&ready.
  - At full, no push even if a pop happens in the same cycle.
  - Pop when slot==HWR. Push and pop in the same cycle (not full) leave the level unchanged.
  - Drains in strict arrival order.
- Host read:
  - host_rd_ready = fifo_empty && !rd_pending && !push_this_cycle. This guarantees read-after-write ordering.
  - On accept, the address is latched and rd_pending=1.
  - The read issues at the first cycle with no disp_req; the accept cycle itself is eligible.
  - rd_pending clears on issue. host_rd_rvalid is 1 the following cycle.
- stall_cnt:
  - Increments when slot==DISP and (rd_pending || !fifo_empty).
  - Saturates at 2^STALL_W-1. Cleared only by rst.
- Reset values:
  - fifo_level=0, host_wr_ready=1, host_rd_ready=1.
  - rd_pending=0, last_src=NONE.
  - disp_rvalid=0, host_rd_rvalid=0, stall_cnt=0.
- Reset mid-operation:
  - Queued writes and the pending read are discarded, never issued.
  - No rvalid is produced for an access issued in the cycle rst asserts.
- Address wrap: addresses are used as-is. No bounds checking; out-of-range addresses are impossible by width.

Decomposition:
- vga_mem_pkg:
  - slot_src_e enum (NONE, DISP, HRD, HWR).
  - Default ADDR_W/DATA_W localparams shared with the VGA pattern and SPI blocks.
- Sub-module sync_fifo (DEPTH, WIDTH = ADDR_W+DATA_W):
  - push/pop/full/empty/level.
  - Synchronous active-high reset.

Test Plan:
- Reset: hold rst 3 cycles with random inputs. Required:
  - mem_en=0, mem_we=0 throughout.
  - After release: host_wr_ready=1, host_rd_ready=1, fifo_level=0, stall_cnt=0.
- FIFO full under display hold: disp_req=1 for 10 cycles while offering 5 writes (addr 0x010..0x014, data 0xA0..0xA4). Required:
  - 4 accepted; host_wr_ready=0 after the 4th.
  - stall_cnt=10.
  - After disp_req drops: mem_we on 4 consecutive cycles, addr 0x010..0x013 in order.
  - Then the 5th write is accepted and issued.
- Read-after-write: write 0x055=0x3C, then read 0x055 in the next cycle. Required:
  - host_rd_ready=0 until the FIFO is empty.
  - host_rd_rvalid=1 with host_rd_rdata=0x3C exactly one cycle after the read issue.
- Priority collision: at cycle t, disp_req (addr 0x100) and host read (addr 0x200) with an empty FIFO. Required:
  - mem_addr=0x100 at t, 0x200 at t+1.
  - disp_rvalid at t+1, host_rd_rvalid at t+2.
- Reset mid-operation: queue 3 writes under disp hold and a pending read, then pulse rst 1 cycle. Required:
  - No mem_we and no host_rd_rvalid afterwards.
  - fifo_level=0, stall_cnt=0.
- Saturation (STALL_W=4): pending write with disp_req held 40 cycles. Required: stall_cnt stops at 15 and does not wrap.
